// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU issue path: widths, opcodes and issue FSM encoding.
package alu4_pkg;

  localparam int unsigned OPW = 3;
  localparam int unsigned DW  = 4;
  localparam int unsigned RW  = 8;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_CMP = 3'b010;
  localparam logic [OPW-1:0] OP_3   = 3'b011;
  localparam logic [OPW-1:0] OP_SHF = 3'b100;
  localparam logic [OPW-1:0] OP_5   = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/alu4_op_fifo.sv
// Synchronous FIFO holding queued ALU operations; no bypass, head valid the cycle after a write.
module alu4_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pushes while full and pops while empty are dropped, so count cannot wrap.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu4_issue_queue.sv
// Issues queued operations to the external 4-bit ALU one at a time and captures each result
// into a valid/ready output register.
module alu4_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = alu4_pkg::DW,
  parameter int unsigned OPW   = alu4_pkg::OPW,
  parameter int unsigned RW    = alu4_pkg::RW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OPW-1:0]               in_op,
  input  logic [DW-1:0]                in_a,
  input  logic [DW-1:0]                in_b,
  input  logic                         in_cin,
  output logic [OPW-1:0]               alu_op,
  output logic [DW-1:0]                alu_a,
  output logic [DW-1:0]                alu_b,
  output logic                         alu_cin,
  input  logic [RW-1:0]                alu_out,
  input  logic                         alu_cout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RW-1:0]                res_out,
  output logic                         res_cout,
  output logic [OPW-1:0]               res_op,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  import alu4_pkg::*;

  localparam int unsigned EW = OPW + 2*DW + 1;

  logic [1:0]     state_q, state_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic           alu_cin_q, alu_cin_d;
  logic           res_valid_q, res_valid_d;
  logic [RW-1:0]  res_out_q, res_out_d;
  logic           res_cout_q, res_cout_d;
  logic [OPW-1:0] res_op_q, res_op_d;

  logic           pop_c;
  logic [EW-1:0]  head;
  logic           fifo_full, fifo_empty;

  alu4_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data ({in_op, in_a, in_b, in_cin}),
    .pop     (pop_c),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_cout  = res_cout_q;
  assign res_op    = res_op_q;

  // Issue FSM: alu_* only move on a pop; results are captured at the end of DRIVE.
  always_comb begin
    state_d     = state_q;
    pop_c       = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_cout_d  = res_cout_q;
    res_op_d    = res_op_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          {alu_op_d, alu_a_d, alu_b_d, alu_cin_d} = head;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        res_out_d   = alu_out;
        res_cout_d  = alu_cout;
        res_op_d    = alu_op_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop_c = 1'b1;
            {alu_op_d, alu_a_d, alu_b_d, alu_cin_d} = head;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_cout_q  <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_cout_q  <= res_cout_d;
      res_op_q    <= res_op_d;
    end
  end

endmodule

// File: tb/tb_alu4_issue_queue.sv
// Bench for alu4_issue_queue: behavioural ALU model on the alu_* ports and an in-order result scoreboard.
module tb_alu4_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned OPW   = 3;
  localparam int unsigned RW    = 8;
  localparam int unsigned CW    = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic           in_cin;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic           alu_cin;
  logic [RW-1:0]  alu_out;
  logic           alu_cout;
  logic           res_valid;
  logic           res_ready;
  logic [RW-1:0]  res_out;
  logic           res_cout;
  logic [OPW-1:0] res_op;
  logic [CW-1:0]  count;
  logic           busy;

  int tests_run;
  int tests_failed;
  int n_results;

  logic [OPW+RW:0] exp_q[$];

  alu4_issue_queue #(.DEPTH(DEPTH), .DW(DW), .OPW(OPW), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_out   (res_out),
    .res_cout  (res_cout),
    .res_op    (res_op),
    .count     (count),
    .busy      (busy)
  );

  // Behavioural ALU: returns {cout, out}.
  function automatic logic [RW:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
    logic [4:0]  s;
    logic [7:0]  ab;
    logic [RW:0] r;
    s  = '0;
    ab = {a, b};
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b} + {4'b0, cin}; r = {s[4], 3'b0, s}; end
      3'b001: begin s = {1'b0, a} - {1'b0, b} - {4'b0, cin}; r = {s[4], 3'b0, s}; end
      3'b010: r = {1'b0, 7'b0, (a == b)};
      3'b011: r = {1'b0, 4'b0, a & b};
      3'b100: r = {a[3], ab << cin};
      3'b101: r = {1'b0, 8'({4'b0, a} * {4'b0, b})};
      default: r = {1'b0, 4'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_cout, alu_out} = alu_model(alu_op, alu_a, alu_b, alu_cin);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  initial begin : monitor
    logic                 hold_prev;
    logic [RW-1:0]        prev_out;
    logic                 prev_cout;
    logic [OPW-1:0]       prev_op;
    logic [OPW+2*DW:0]    prev_alu;
    logic [OPW+RW:0]      exp;
    hold_prev = 1'b0;
    prev_out  = '0;
    prev_cout = 1'b0;
    prev_op   = '0;
    prev_alu  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          tests_run++;
          if (res_valid !== 1'b1 || res_out !== prev_out || res_cout !== prev_cout ||
              res_op !== prev_op || {alu_op, alu_a, alu_b, alu_cin} !== prev_alu) begin
            tests_failed++;
            $display("FAIL hold_stable: got valid=%0b out=%h cout=%0b op=%0d alu=%h, want valid=1 out=%h cout=%0b op=%0d alu=%h",
                     res_valid, res_out, res_cout, res_op, {alu_op, alu_a, alu_b, alu_cin},
                     prev_out, prev_cout, prev_op, prev_alu);
          end
        end
        if (res_valid && res_ready) begin
          tests_run++;
          n_results++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_result: got op=%0d cout=%0b out=%h with empty scoreboard",
                     res_op, res_cout, res_out);
          end else begin
            exp = exp_q.pop_front();
            if ({res_op, res_cout, res_out} !== exp) begin
              tests_failed++;
              $display("FAIL result_order: got op=%0d cout=%0b out=%h, want op=%0d cout=%0b out=%h",
                       res_op, res_cout, res_out, exp[RW+OPW:RW+1], exp[RW], exp[RW-1:0]);
            end
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back({in_op, alu_model(in_op, in_a, in_b, in_cin)});
        hold_prev = res_valid && !res_ready;
        prev_out  = res_out;
        prev_cout = res_cout;
        prev_op   = res_op;
        prev_alu  = {alu_op, alu_a, alu_b, alu_cin};
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || res_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (busy || res_valid) begin
      tests_failed++;
      $display("FAIL drain_timeout: busy=%0b res_valid=%0b, want 0/0", busy, res_valid);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_state();
    tests_run++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0 ||
        alu_a !== 4'd0 || alu_op !== 3'd0 || res_out !== 8'h00 || res_op !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%0b res_valid=%0b count=%0d busy=%0b alu_a=%0d alu_op=%0d res_out=%h res_op=%0d, want 1 0 0 0 0 0 00 0",
               in_ready, res_valid, count, busy, alu_a, alu_op, res_out, res_op);
    end
  endtask

  task automatic test_single_op();
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b000;
    in_a      = 4'b0011;
    in_b      = 4'b0011;
    in_cin    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_e0: count=%0d res_valid=%0b, want 1 0", count, res_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (alu_a !== 4'b0011 || alu_b !== 4'b0011 || alu_op !== 3'b000 || alu_cin !== 1'b0 ||
        res_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_e1: alu_a=%0d alu_b=%0d alu_op=%0d res_valid=%0b count=%0d, want 3 3 0 0 0",
               alu_a, alu_b, alu_op, res_valid, count);
    end
    @(posedge clk); #1;
    tests_run++;
    if (res_valid !== 1'b1 || res_out !== 8'h06 || res_op !== 3'b000 || res_cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_e2: res_valid=%0b res_out=%h res_op=%0d res_cout=%0b, want 1 06 0 0",
               res_valid, res_out, res_op, res_cout);
    end
    res_ready = 1'b1;
    wait_idle();
    tests_run++;
    if (alu_a !== 4'b0011) begin
      tests_failed++;
      $display("FAIL idle_alu_hold: alu_a=%0d, want 3", alu_a);
    end
  endtask

  task automatic test_backpressure_full();
    int k;
    int hs;
    int last;
    logic [2:0] ops [5];
    ops[0] = 3'b001; ops[1] = 3'b101; ops[2] = 3'b100; ops[3] = 3'b010; ops[4] = 3'b011;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(ops[i], 4'(i + 5), 4'(i + 2), 1'(i));
    tests_run++;
    if (count !== 3'd4 || in_ready !== 1'b0 || res_valid !== 1'b1 || res_op !== ops[0]) begin
      tests_failed++;
      $display("FAIL full_state: count=%0d in_ready=%0b res_valid=%0b res_op=%0d, want 4 0 1 %0d",
               count, in_ready, res_valid, res_op, ops[0]);
    end
    in_valid = 1'b1;
    in_op    = 3'b110;
    in_a     = 4'hF;
    in_b     = 4'hF;
    in_cin   = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drop: count=%0d in_ready=%0b, want 4 0", count, in_ready);
    end
    res_ready = 1'b1;
    hs   = 0;
    last = -1;
    for (k = 0; k < 20 && hs < 5; k++) begin
      if (res_valid) begin
        if (last >= 0) begin
          tests_run++;
          if (k - last != 2) begin
            tests_failed++;
            $display("FAIL result_spacing: gap=%0d cycles, want 2", k - last);
          end
        end
        last = k;
        hs++;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (hs != 5) begin
      tests_failed++;
      $display("FAIL drain_count: got %0d results, want 5", hs);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    push_op(3'b000, 4'hA, 4'h1, 1'b0);
    push_op(3'b011, 4'hB, 4'h6, 1'b0);
    push_op(3'b001, 4'hC, 4'h3, 1'b1);
    tests_run++;
    if (count !== 3'd2 || res_valid !== 1'b1 || alu_a !== 4'hA) begin
      tests_failed++;
      $display("FAIL b2b_pre: count=%0d res_valid=%0b alu_a=%h, want 2 1 a", count, res_valid, alu_a);
    end
    in_valid  = 1'b1;
    in_op     = 3'b101;
    in_a      = 4'hD;
    in_b      = 4'h2;
    in_cin    = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2 || alu_a !== 4'hB || alu_op !== 3'b011 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_pushpop: count=%0d alu_a=%h alu_op=%0d res_valid=%0b, want 2 b 3 0",
               count, alu_a, alu_op, res_valid);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    int start;
    start     = n_results;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_op(3'(i % 6), 4'(i), 4'(9 - i), 1'(i));
    wait_idle();
    tests_run++;
    if (n_results - start != 10) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d results, want 10", n_results - start);
    end
  endtask

  task automatic test_reset_midhold();
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_op(3'b000, 4'(i), 4'(i), 1'b0);
    tests_run++;
    if (res_valid !== 1'b1 || count !== 3'd3 || alu_a !== 4'd1) begin
      tests_failed++;
      $display("FAIL pre_reset: res_valid=%0b count=%0d alu_a=%0d, want 1 3 1", res_valid, count, alu_a);
    end
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_op    = 3'b001;
    in_a     = 4'h7;
    in_b     = 4'h1;
    #1;
    exp_q.delete();
    tests_run++;
    if (res_valid !== 1'b0 || count !== 3'd0 || alu_a !== 4'd0 || in_ready !== 1'b1 ||
        res_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: res_valid=%0b count=%0d alu_a=%0d in_ready=%0b res_out=%h, want 0 0 0 1 00",
               res_valid, count, alu_a, in_ready, res_out);
    end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++;
      $display("FAIL push_in_reset: count=%0d, want 0", count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || count !== 3'd0 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: in_ready=%0b busy=%0b count=%0d res_valid=%0b, want 1 0 0 0",
               in_ready, busy, count, res_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_results    = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_op        = '0;
    in_a         = '0;
    in_b         = '0;
    in_cin       = 1'b0;
    res_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset_state();
    test_single_op();
    test_backpressure_full();
    test_back_to_back();
    test_wrap();
    test_reset_midhold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
